ks_i2s_tx: RTL and testbench

- Output stage for the Karplus-Strong voice. It consumes signed 8-bit string samples over a valid/ready handshake and serialises each one as a mono I2S frame, with the same sample on the left and right slots.
- It generates its own bit clock (bclk) and word-select clock (lrclk) from clk_i.
- It emits a once-per-frame sample request pulse. The pulse paces the synth upstream, typically through that block's freeze input.

---
 rtl/ks_audio_pkg.sv | 13 +
 rtl/ks_bclk_gen.sv | 40 ++++
 rtl/ks_i2s_tx.sv | 111 +++++++++++
 tb/tb_ks_i2s_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_audio_pkg.sv
// Shared constants and FSM encoding for the Karplus-Strong audio output path.
package ks_audio_pkg;

  localparam int KS_DATA_WIDTH = 8;
  localparam int KS_SLOT_WIDTH = 16;
  localparam int KS_FRAME_LEN  = 2 * KS_SLOT_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

endpackage

// File: rtl/ks_bclk_gen.sv
// I2S bit clock divider: toggles bclk every BCLK_DIV clocks while enabled and
// flags the clock cycle preceding each bclk edge with a one-cycle strobe.
module ks_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic bclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             wrap;

  assign wrap   = en_i && (div_cnt == CNT_LAST);
  assign rise_o = wrap && !bclk_o;
  assign fall_o = wrap && bclk_o;

  // Disabling parks the divider low so the next run starts with a rising half-period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt <= '0;
      bclk_o  <= 1'b0;
    end else if (!en_i) begin
      div_cnt <= '0;
      bclk_o  <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk_o  <= !bclk_o;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ks_i2s_tx.sv
// Mono I2S transmitter: one-sample holding register feeding a frame shift
// register, with bypass on an empty load and a sticky underrun flag.
module ks_i2s_tx
  import ks_audio_pkg::*;
#(
  parameter int DATA_WIDTH = KS_DATA_WIDTH,
  parameter int SLOT_WIDTH = KS_SLOT_WIDTH,
  parameter int BCLK_DIV   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic                         sample_valid_i,
  output logic                         sample_ready_o,
  output logic                         sample_req_o,
  output logic                         underrun_o,
  input  logic                         clear_underrun_i,
  output logic                         bclk_o,
  output logic                         lrclk_o,
  output logic                         sdata_o
);

  localparam int FRAME_LEN = 2 * SLOT_WIDTH;
  localparam int B_W       = $clog2(FRAME_LEN);
  localparam logic [B_W-1:0] B_LAST = B_W'(FRAME_LEN - 1);

  function automatic logic [SLOT_WIDTH-1:0] slot_word(input logic signed [DATA_WIDTH-1:0] s);
    logic [SLOT_WIDTH-1:0] w;
    w = SLOT_WIDTH'($unsigned(s));
    return w << (SLOT_WIDTH - DATA_WIDTH);
  endfunction

  i2s_state_t                   state, state_next;
  logic                         rise, fall;
  logic [B_W-1:0]               b, b_next;
  logic                         load_arm, load, frame_end, stop, xfer;
  logic                         hold_full;
  logic signed [DATA_WIDTH-1:0] hold_data;
  logic [SLOT_WIDTH-1:0]        new_word;
  logic [FRAME_LEN-1:0]         frame_word, shreg;

  ks_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state == RUN),
    .bclk_o (bclk_o),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign sample_ready_o = !hold_full;
  assign xfer           = sample_valid_i && !hold_full;
  assign b_next         = (b == B_LAST) ? '0 : b + 1'b1;
  assign frame_end      = fall && (b == B_LAST);
  assign stop           = frame_end && !enable_i;
  // The rise of bit 0 arms the load; the following fall performs it.
  assign load           = fall && load_arm;
  assign new_word       = hold_full ? slot_word(hold_data) :
                          xfer      ? slot_word(sample_i)  : '0;
  assign frame_word     = {new_word, new_word};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable_i) state_next = RUN;
      RUN:     if (stop)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      b            <= '0;
      load_arm     <= 1'b0;
      lrclk_o      <= 1'b0;
      sdata_o      <= 1'b0;
      sample_req_o <= 1'b0;
      underrun_o   <= 1'b0;
      hold_full    <= 1'b0;
    end else begin
      state        <= state_next;
      sample_req_o <= load;
      if (rise && (b == '0)) load_arm <= 1'b1;
      else if (fall)         load_arm <= 1'b0;
      if (fall) begin
        if (stop) begin
          b       <= '0;
          lrclk_o <= 1'b0;
          sdata_o <= 1'b0;
        end else begin
          b       <= b_next;
          lrclk_o <= (b_next >= B_W'(SLOT_WIDTH));
          sdata_o <= load ? frame_word[FRAME_LEN-1] : shreg[FRAME_LEN-1];
        end
      end
      if (load)      hold_full <= 1'b0;
      else if (xfer) hold_full <= 1'b1;
      if (load && !hold_full && !xfer) underrun_o <= 1'b1;
      else if (clear_underrun_i)       underrun_o <= 1'b0;
    end
  end

  // Datapath registers: contents are qualified by hold_full / the frame counter.
  always_ff @(posedge clk_i) begin
    if (xfer && !load) hold_data <= sample_i;
    if (fall) shreg <= load ? {frame_word[FRAME_LEN-2:0], 1'b0} : {shreg[FRAME_LEN-2:0], 1'b0};
  end

endmodule

// File: tb/tb_ks_i2s_tx.sv
// Bench for ks_i2s_tx: timeline-based reference model checked every cycle,
// plus directed scenarios with hand-computed frame contents.
module tb_ks_i2s_tx;

  localparam int DIV = 4;
  localparam int SW  = 16;
  localparam int FL  = 2 * SW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic              valid = 1'b0;
  logic              clr = 1'b0;
  logic signed [7:0] data = 8'sd0;
  logic              ready, req, ur, bclk, lrclk, sdata;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  ks_i2s_tx dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (ena),
    .sample_i         (data),
    .sample_valid_i   (valid),
    .sample_ready_o   (ready),
    .sample_req_o     (req),
    .underrun_o       (ur),
    .clear_underrun_i (clr),
    .bclk_o           (bclk),
    .lrclk_o          (lrclk),
    .sdata_o          (sdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time in RUN determines bclk/bit index; each frame's word
  // comes from a one-entry buffer with bypass and underrun rules.
  bit          m_run = 0;
  int          m_t = 0;
  bit          m_hold_full = 0;
  logic [7:0]  m_hold = 8'h00;
  logic [15:0] m_cur = 16'h0000;
  bit          m_ur = 0;
  bit          m_req = 0;

  function automatic logic [15:0] word_of(input logic [7:0] s);
    return {s, 8'h00};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit load, stop, set_ur;
    int tn, h;
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_hold_full = 0; m_cur = 16'h0; m_ur = 0; m_req = 0;
    end else begin
      load = 0; stop = 0;
      if (m_run) begin
        tn = m_t + 1;
        h  = tn / DIV;
        if ((tn % DIV == 0) && (h % 64 == 2)) load = 1;
        if ((tn % DIV == 0) && (h % 64 == 0) && !ena) stop = 1;
        m_t = tn;
      end else if (ena) begin
        m_run = 1; m_t = 0;
      end
      set_ur = load && !m_hold_full && !valid;
      if (load) begin
        if (m_hold_full) begin m_cur = word_of(m_hold); m_hold_full = 0; end
        else if (valid)  m_cur = word_of(data);
        else             m_cur = 16'h0000;
      end else if (valid && !m_hold_full) begin
        m_hold_full = 1; m_hold = data;
      end
      if (set_ur)   m_ur = 1;
      else if (clr) m_ur = 0;
      m_req = load;
      if (stop) begin m_run = 0; m_t = 0; end
    end
  end

  always @(negedge clk) begin
    logic eb, el, es;
    int h, b;
    eb = 1'b0; el = 1'b0; es = 1'b0;
    if (m_run) begin
      h  = m_t / DIV;
      b  = (h / 2) % FL;
      eb = (h % 2 == 1);
      el = (b >= SW);
      if (b == 0) es = (h < 2) ? 1'b0 : m_cur[0];
      else        es = m_cur[15 - ((b - 1) % SW)];
    end
    check("bclk", 64'(bclk), 64'(eb));
    check("lrclk", 64'(lrclk), 64'(el));
    check("sdata", 64'(sdata), 64'(es));
    check("ready", 64'(ready), 64'(!m_hold_full));
    check("req", 64'(req), 64'(m_req));
    check("underrun", 64'(ur), 64'(m_ur));
    if (req === 1'b1) req_cnt++;
  end

  task automatic wait_req();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req !== 1'b1 && n < 400);
    if (req !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_req: no sample_req_o within %0d cycles, expected 1", n);
    end
  endtask

  // Collect sdata/lrclk on the next n bclk rises, MSB = first rise.
  task automatic capture(input int n, output logic [63:0] sd, output logic [63:0] lr, output int period);
    int got, cyc, first, second;
    logic prev;
    got = 0; cyc = 0; first = 0; second = 0;
    sd = '0; lr = '0;
    prev = bclk;
    while (got < n && cyc < n * 20) begin
      @(negedge clk);
      cyc++;
      if (bclk === 1'b1 && prev === 1'b0) begin
        sd = {sd[62:0], sdata};
        lr = {lr[62:0], lrclk};
        if (got == 0) first = cyc;
        if (got == 1) second = cyc;
        got++;
      end
      prev = bclk;
    end
    if (got < n) begin
      checks++; errors++;
      $display("FAIL capture: got %0d rises, expected %0d", got, n);
    end
    period = second - first;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] sd, lr;
    int per, r0, xfers, n;
    logic will;

    repeat (3) @(negedge clk);
    check("rst_bclk", 64'(bclk), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_req", 64'(req), 64'd0);
    check("rst_underrun", 64'(ur), 64'd0);
    rst_n = 1'b1;

    // Sample 0xA5 buffered before the first frame.
    @(negedge clk); valid = 1'b1; data = 8'shA5;
    @(negedge clk); valid = 1'b0; ena = 1'b1;
    r0 = req_cnt;
    capture(33, sd, lr, per);
    check("a5_frame", sd & 64'h1_FFFF_FFFF, {31'd0, 1'b0, 16'hA500, 16'hA500});
    check("a5_lrclk", lr & 64'h1_FFFF_FFFF, 64'h0_0001_FFFE);
    check("bclk_period", 64'(per), 64'd8);
    check("a5_req_once", 64'(req_cnt - r0), 64'd1);

    // Empty load: zero slots and underrun.
    wait_req();
    check("underrun_set", 64'(ur), 64'd1);
    capture(16, sd, lr, per);
    check("zero_frame", sd & 64'hFFFF, 64'h0000);

    // Clear, then present 0x80 exactly in the next load cycle.
    wait_req();
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("underrun_clear", 64'(ur), 64'd0);
    repeat (254) @(negedge clk);
    valid = 1'b1; data = 8'sh80;
    @(negedge clk); valid = 1'b0;
    check("bypass_req", 64'(req), 64'd1);
    check("bypass_no_underrun", 64'(ur), 64'd0);
    capture(16, sd, lr, per);
    check("bypass_frame", sd & 64'hFFFF, 64'h8000);

    // Steady stream 0x01, 0x02, ... over four frames.
    wait_req();
    valid = 1'b1; data = 8'sd1; clr = 1'b1; xfers = 0;
    for (int i = 0; i < 1024; i++) begin
      will = ready;
      if (will) xfers++;
      @(negedge clk);
      clr = 1'b0;
      if (will) data = data + 8'sd1;
    end
    valid = 1'b0;
    check("stream_xfers", 64'(xfers), 64'd4);
    check("stream_underrun", 64'(ur), 64'd0);

    // Drop enable at b = 5 and buffer a sample during the tail.
    wait_req();
    repeat (32) @(negedge clk);
    ena = 1'b0; valid = 1'b1; data = 8'sh3C;
    @(negedge clk); valid = 1'b0;
    repeat (240) @(negedge clk);
    check("idle_bclk", 64'(bclk), 64'd0);
    check("idle_lrclk", 64'(lrclk), 64'd0);
    check("idle_sdata", 64'(sdata), 64'd0);
    check("idle_retained", 64'(ready), 64'd0);
    ena = 1'b1;
    capture(17, sd, lr, per);
    check("retained_frame", sd & 64'h1FFFF, 64'h03C00);

    // Randomized traffic, enable toggling and clears.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 3) == 0);
      data  = 8'($urandom);
      clr   = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 599) == 0) ena = ~ena;
    end

    // Asynchronous reset mid-frame.
    @(negedge clk); ena = 1'b1; valid = 1'b0; clr = 1'b0;
    repeat (600) @(negedge clk);
    check("pre_reset_underrun", 64'(ur), 64'd1);
    valid = 1'b1; data = 8'sh11;
    @(negedge clk); valid = 1'b0;
    n = 0;
    while (!(bclk === 1'b1 && lrclk === 1'b1) && n < 300) begin
      @(negedge clk); n++;
    end
    check("pre_reset_high", 64'({bclk, lrclk}), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bclk", 64'(bclk), 64'd0);
    check("arst_lrclk", 64'(lrclk), 64'd0);
    check("arst_sdata", 64'(sdata), 64'd0);
    check("arst_underrun", 64'(ur), 64'd0);
    check("arst_ready", 64'(ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; ena = 1'b0;
    @(negedge clk); valid = 1'b1; data = 8'sh5A;
    @(negedge clk); valid = 1'b0; ena = 1'b1;
    capture(17, sd, lr, per);
    check("post_reset_frame", sd & 64'h1FFFF, 64'h05A00);
    check("post_reset_lrclk", lr & 64'h1FFFF, 64'h00001);
    check("post_reset_period", 64'(per), 64'd8);

    ena = 1'b0;
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
